// File: rtl/dist_filter.sv
// Distance smoother: 4-sample moving average with a hysteretic near alarm and a miss fault.
// Defining DIST_MEDIAN_EN adds a median-of-3 prefilter (extra MED state, one more cycle latency).
module dist_filter #(
    parameter int unsigned THRESH_NEAR = 300,
    parameter int unsigned HYST        = 50,
    parameter int unsigned MAX_MISS    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [11:0] in_dist,
    output logic [11:0] avg_dist,
    output logic        avg_val,
    output logic        near,
    output logic        fault,
    output logic [2:0]  dbg_state_o
);
    // in_val is a one-cycle strobe with no ready: it is consumed only in IDLE and silently
    // dropped in every other state; avg_val is a one-cycle strobe with no backpressure.

    localparam logic [12:0] NEAR_SET = 13'(THRESH_NEAR);
    localparam logic [12:0] NEAR_CLR = 13'(THRESH_NEAR + HYST);
    localparam logic [3:0]  MISS_LIM = 4'(MAX_MISS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INS  = 3'd1,
        S_SUM  = 3'd2,
`ifdef DIST_MEDIAN_EN
        S_MED  = 3'd4,
`endif
        S_OUT  = 3'd3
    } state_t;

    state_t      state_q;
    logic [11:0] win_q [4];
    logic [2:0]  fill_q;
    logic [3:0]  miss_q;
    logic [11:0] sample_q;
    logic [11:0] avg_q;
    logic        avg_val_q;
    logic        near_q;
    logic        fault_q;

    logic [13:0] sum_d;
    logic [11:0] avg_d;
    logic [3:0]  miss_d;

    assign sum_d  = 14'(win_q[0]) + 14'(win_q[1]) + 14'(win_q[2]) + 14'(win_q[3]);
    assign avg_d  = 12'(sum_d >> 2);
    assign miss_d = (miss_q == 4'd15) ? miss_q : miss_q + 4'd1;

`ifdef DIST_MEDIAN_EN
    logic [11:0] raw_q [3];
    logic [1:0]  raw_cnt_q;
    logic [11:0] med_d;

    function automatic logic [11:0] med3(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    // Until three raw samples have been seen the newest raw value passes straight through.
    assign med_d = (raw_cnt_q == 2'd3) ? med3(raw_q[0], raw_q[1], raw_q[2]) : raw_q[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            fill_q    <= '0;
            miss_q    <= '0;
            sample_q  <= '0;
            avg_q     <= '0;
            avg_val_q <= 1'b0;
            near_q    <= 1'b0;
            fault_q   <= 1'b0;
`ifdef DIST_MEDIAN_EN
            for (int i = 0; i < 3; i++) raw_q[i] <= '0;
            raw_cnt_q <= '0;
`endif
        end else begin
            avg_val_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_val) begin
                        if (in_dist == 12'd0) begin
                            miss_q <= miss_d;
                            if (miss_d >= MISS_LIM) fault_q <= 1'b1;
                        end else begin
                            miss_q  <= '0;
                            fault_q <= 1'b0;
`ifdef DIST_MEDIAN_EN
                            raw_q[0] <= in_dist;
                            raw_q[1] <= raw_q[0];
                            raw_q[2] <= raw_q[1];
                            if (raw_cnt_q != 2'd3) raw_cnt_q <= raw_cnt_q + 2'd1;
                            state_q <= S_MED;
`else
                            sample_q <= in_dist;
                            state_q  <= S_INS;
`endif
                        end
                    end
                end
`ifdef DIST_MEDIAN_EN
                S_MED: begin
                    sample_q <= med_d;
                    state_q  <= S_INS;
                end
`endif
                S_INS: begin
                    win_q[0] <= sample_q;
                    win_q[1] <= win_q[0];
                    win_q[2] <= win_q[1];
                    win_q[3] <= win_q[2];
                    if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    // Outputs register here so avg_val is high during the OUT cycle.
                    if (fill_q == 3'd4) begin
                        avg_q     <= avg_d;
                        avg_val_q <= 1'b1;
                        if ({1'b0, avg_d} < NEAR_SET) near_q <= 1'b1;
                        else if ({1'b0, avg_d} >= NEAR_CLR) near_q <= 1'b0;
                    end
                    state_q <= S_OUT;
                end
                S_OUT:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign avg_dist    = avg_q;
    assign avg_val     = avg_val_q;
    assign near        = near_q;
    assign fault       = fault_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dist_filter.sv
// Bench for dist_filter: directed and random samples against a queue-based reference model.
// Honours DIST_MEDIAN_EN the same way the design does.
module tb_dist_filter;
    localparam int THRESH = 300;
    localparam int HYST   = 50;
    localparam int MAXM   = 3;
`ifdef DIST_MEDIAN_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_val = 1'b0;
    logic [11:0] in_dist = '0;
    logic [11:0] avg_dist;
    logic        avg_val;
    logic        near;
    logic        fault;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: accepted values, raw nonzero history, miss count, alarm, last avg.
    int hist[$];
    int raw[$];
    int m_miss = 0;
    bit m_near = 1'b0;
    int m_avg  = 0;

    dist_filter #(.THRESH_NEAR(THRESH), .HYST(HYST), .MAX_MISS(MAXM)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_dist(in_dist),
        .avg_dist(avg_dist), .avg_val(avg_val), .near(near), .fault(fault),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int med3(input int a, input int b, input int c);
        int mx;
        int mn;
        mx = (a > b) ? a : b;
        mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b;
        mn = (mn < c) ? mn : c;
        return a + b + c - mx - mn;
    endfunction

    task automatic model_reset();
        hist.delete();
        raw.delete();
        m_miss = 0;
        m_near = 1'b0;
        m_avg  = 0;
    endtask

    task automatic model_sample(input int d, output bit exp_pulse);
        int v;
        int s;
        exp_pulse = 1'b0;
        if (d == 0) begin
            if (m_miss < 15) m_miss++;
        end else begin
            m_miss = 0;
            v = d;
`ifdef DIST_MEDIAN_EN
            raw.push_back(d);
            if (raw.size() > 3) void'(raw.pop_front());
            if (raw.size() == 3) v = med3(raw[0], raw[1], raw[2]);
`endif
            hist.push_back(v);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4) begin
                s = 0;
                foreach (hist[i]) s += hist[i];
                m_avg = s / 4;
                if (m_avg < THRESH) m_near = 1'b1;
                else if (m_avg >= THRESH + HYST) m_near = 1'b0;
                exp_pulse = 1'b1;
            end
        end
    endtask

    // Pulses in_val for one cycle, then watches up to 8 cycles for avg_val.
    task automatic drive_sample(input logic [11:0] d, output bit seen, output int lat,
                                output logic [11:0] a, output logic nr);
        seen = 1'b0;
        lat  = 0;
        a    = '0;
        nr   = 1'b0;
        @(negedge clk);
        in_val  = 1'b1;
        in_dist = d;
        @(negedge clk);
        in_val = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (avg_val) begin
                seen = 1'b1;
                lat  = k;
                a    = avg_dist;
                nr   = near;
                break;
            end
            if (k < 8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (avg_dist !== 12'd0 || avg_val !== 1'b0 || near !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got avg=%0d val=%b near=%b fault=%b, required all 0",
                     avg_dist, avg_val, near, fault);
        end
        model_reset();
    endtask

    task automatic test_average();
        int s[6] = '{100, 200, 300, 400, 400, 400};
        bit seen;
        bit ep;
        int lat;
        logic [11:0] a;
        logic nr;
        for (int i = 0; i < 6; i++) begin
            drive_sample(12'(s[i]), seen, lat, a, nr);
            model_sample(s[i], ep);
            n_tests++;
            if (seen !== ep) begin
                n_fail++;
                $display("FAIL avg_pulse[%0d]: got %b, required %b", i, seen, ep);
            end
            if (seen && ep) begin
                n_tests++;
                if (a !== 12'(m_avg) || nr !== m_near) begin
                    n_fail++;
                    $display("FAIL avg_value[%0d]: got avg=%0d near=%b, required avg=%0d near=%b",
                             i, a, nr, m_avg, m_near);
                end
                n_tests++;
                if (lat !== LAT) begin
                    n_fail++;
                    $display("FAIL avg_latency[%0d]: got %0d, required %0d", i, lat, LAT);
                end
            end
`ifndef DIST_MEDIAN_EN
            if (i == 3) begin
                n_tests++;
                if (a !== 12'd250 || nr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_avg: got avg=%0d near=%b, required 250 near=1", a, nr);
                end
            end
            if (i == 5) begin
                n_tests++;
                if (a !== 12'd375 || nr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL release_avg: got avg=%0d near=%b, required 375 near=0", a, nr);
                end
            end
`endif
            if (i == 3) begin
                @(negedge clk);
                n_tests++;
                if (avg_val !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pulse_width: got avg_val=%b one cycle later, required 0", avg_val);
                end
            end
            if (!ep) begin
                n_tests++;
                if (avg_dist !== 12'(m_avg)) begin
                    n_fail++;
                    $display("FAIL avg_hold[%0d]: got %0d, required %0d", i, avg_dist, m_avg);
                end
            end
        end
    endtask

    task automatic test_truncation();
        int s[8] = '{1, 1, 1, 2, 4095, 4095, 4095, 4095};
        bit seen;
        bit ep;
        int lat;
        logic [11:0] a;
        logic nr;
        for (int i = 0; i < 8; i++) begin
            drive_sample(12'(s[i]), seen, lat, a, nr);
            model_sample(s[i], ep);
            n_tests++;
            if (seen !== ep || a !== 12'(m_avg) || nr !== m_near) begin
                n_fail++;
                $display("FAIL trunc[%0d]: got pulse=%b avg=%0d near=%b, required pulse=%b avg=%0d near=%b",
                         i, seen, a, nr, ep, m_avg, m_near);
            end
`ifndef DIST_MEDIAN_EN
            if (i == 3 || i == 7) begin
                n_tests++;
                if (a !== ((i == 3) ? 12'd1 : 12'd4095)) begin
                    n_fail++;
                    $display("FAIL trunc_const[%0d]: got %0d, required %0d", i, a,
                             (i == 3) ? 1 : 4095);
                end
            end
`endif
        end
    endtask

    task automatic test_fault();
        bit seen;
        bit ep;
        int lat;
        logic [11:0] a;
        logic nr;
        for (int i = 0; i < 17; i++) begin
            drive_sample(12'd0, seen, lat, a, nr);
            model_sample(0, ep);
            n_tests++;
            if (seen !== 1'b0 || fault !== (m_miss >= MAXM) || avg_dist !== 12'(m_avg)) begin
                n_fail++;
                $display("FAIL miss[%0d]: got pulse=%b fault=%b avg=%0d, required pulse=0 fault=%b avg=%0d",
                         i, seen, fault, avg_dist, m_miss >= MAXM, m_avg);
            end
        end
        drive_sample(12'd500, seen, lat, a, nr);
        model_sample(500, ep);
        n_tests++;
        if (fault !== 1'b0 || seen !== ep || a !== 12'(m_avg) || nr !== m_near) begin
            n_fail++;
            $display("FAIL fault_clear: got fault=%b pulse=%b avg=%0d near=%b, required fault=0 pulse=%b avg=%0d near=%b",
                     fault, seen, a, nr, ep, m_avg, m_near);
        end
    endtask

    task automatic test_reset_mid();
        int seen_cnt;
        seen_cnt = 0;
        @(negedge clk);
        in_val  = 1'b1;
        in_dist = 12'd300;
        @(negedge clk);
        in_val = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            if (avg_val) seen_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (seen_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: got %0d pulses, required 0", seen_cnt);
        end
        n_tests++;
        if (avg_dist !== 12'd0 || near !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got avg=%0d near=%b fault=%b, required all 0",
                     avg_dist, near, fault);
        end
    endtask

    task automatic test_drop_in_sum();
        bit seen;
        bit ep;
        int lat;
        logic [11:0] a;
        logic nr;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(1, 4095);
            drive_sample(12'(d), seen, lat, a, nr);
            model_sample(d, ep);
            n_tests++;
            if (seen !== ep) begin
                n_fail++;
                $display("FAIL refill_pulse[%0d]: got %b, required %b", i, seen, ep);
            end
        end
        d = $urandom_range(1, 4095);
        @(negedge clk);
        in_val  = 1'b1;
        in_dist = 12'(d);
        @(negedge clk);
        in_val = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        in_val  = 1'b1;
        in_dist = 12'($urandom_range(1, 4095));
        @(negedge clk);
        in_val = 1'b0;
        model_sample(d, ep);
        n_tests++;
        if (avg_val !== 1'b1 || avg_dist !== 12'(m_avg)) begin
            n_fail++;
            $display("FAIL drop_sum_avg: got val=%b avg=%0d, required val=1 avg=%0d",
                     avg_val, avg_dist, m_avg);
        end
        repeat (2) @(negedge clk);
        d = $urandom_range(1, 4095);
        drive_sample(12'(d), seen, lat, a, nr);
        model_sample(d, ep);
        n_tests++;
        if (seen !== ep || a !== 12'(m_avg) || nr !== m_near) begin
            n_fail++;
            $display("FAIL drop_window: got pulse=%b avg=%0d near=%b, required pulse=%b avg=%0d near=%b",
                     seen, a, nr, ep, m_avg, m_near);
        end
    endtask

    task automatic test_random();
        bit seen;
        bit ep;
        int lat;
        logic [11:0] a;
        logic nr;
        int r;
        int d;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) d = 0;
            else if (r < 6) d = $urandom_range(250, 400);
            else d = $urandom_range(1, 4095);
            drive_sample(12'(d), seen, lat, a, nr);
            model_sample(d, ep);
            n_tests++;
            if (seen !== ep || avg_dist !== 12'(m_avg) || near !== m_near
                || fault !== (m_miss >= MAXM) || (ep && lat !== LAT)) begin
                n_fail++;
                $display("FAIL random[%0d] d=%0d: got pulse=%b lat=%0d avg=%0d near=%b fault=%b, required pulse=%b lat=%0d avg=%0d near=%b fault=%b",
                         i, d, seen, lat, avg_dist, near, fault, ep, LAT, m_avg, m_near,
                         m_miss >= MAXM);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_average();
        test_truncation();
        test_fault();
        test_reset_mid();
        test_drop_in_sum();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dist_filter.md
DIST_FILTER -- requirements
Module: dist_filter

Interface
REQ-001 Parameter THRESH_NEAR, default 300: near-alarm threshold in mm, 12-bit unsigned.
REQ-002 Parameter HYST, default 50: alarm release hysteresis in mm; THRESH_NEAR+HYST SHALL fit in 13 bits.
REQ-003 Parameter MAX_MISS, default 3: consecutive zero samples that raise fault, range 1..15.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_val  input  1  one-cycle pulse: a new distance from the upstream ranger is valid.
REQ-007 in_dist  input  12  measured distance in mm; 0 means timeout/no echo.
REQ-008 avg_dist  output  12  moving average of the last 4 accepted samples in mm; holds between updates.
REQ-009 avg_val  output  1  one-cycle pulse when avg_dist is updated.
REQ-010 near  output  1  proximity alarm with hysteresis.
REQ-011 fault  output  1  high while MAX_MISS or more consecutive zero samples have arrived.

Function
REQ-012 FSM states IDLE, INS, SUM, OUT; leaves IDLE only on in_val=1.
REQ-013 in_val is ignored outside IDLE; the sample is dropped with no other effect.
REQ-014 Samples with in_dist=0 are misses: not inserted, FSM stays IDLE, miss counter increments and saturates at 15.
REQ-015 fault = 1 from the cycle after the miss counter reaches MAX_MISS; the first nonzero sample clears the counter and fault on the next cycle.
REQ-016 Nonzero sample: INS shifts it into a 4-entry window (oldest discarded) and increments fill count, saturating at 4.
REQ-017 SUM forms a 14-bit sum of all 4 entries; avg = sum >> 2, truncated, with no overflow possible.
REQ-018 OUT occurs only if fill = 4: loads avg_dist and pulses avg_val for exactly one cycle; if fill < 4, no pulse and avg_dist is unchanged.
REQ-019 Latency: in_val at cycle N -> avg_val high at cycle N+3; FSM returns to IDLE at N+4.
REQ-020 near is updated in the same cycle as avg_dist: set if new avg < THRESH_NEAR, cleared if new avg >= THRESH_NEAR+HYST, otherwise held.

Reset
REQ-021 While rst=1: avg_dist=0, avg_val=0, near=0, fault=0; window, fill count and miss counter are cleared; FSM goes to IDLE.
REQ-022 Reset mid-operation discards the in-flight sample; no avg_val is produced for it.
REQ-023 The first sample accepted after reset SHALL be an in_val arriving no earlier than the first cycle with rst=0.

Configuration
REQ-024 Macro DIST_MEDIAN_EN defined: a median-of-3 prefilter runs over the last 3 nonzero raw samples.
REQ-025 With DIST_MEDIAN_EN, the value inserted in INS is that median; until 3 raw samples exist, the raw sample is inserted.
REQ-026 With DIST_MEDIAN_EN, one extra MED state precedes INS and latency becomes N+4.
REQ-027 Without DIST_MEDIAN_EN, no median logic or registers exist and REQ-019 latency applies.

Verification
REQ-028 Samples 100, 200, 300, 400 -> no avg_val for the first three; fourth gives avg_dist=250, near=1, avg_val exactly 3 cycles after in_val.
REQ-029 Then samples 400, 400 -> avg 325 with near held at 1, then avg 375 with near=0.
REQ-030 Samples 1, 1, 1, 2 -> avg_dist=1 (truncation); 4095 x4 -> avg_dist=4095.
REQ-031 Three samples of in_dist=0 (MAX_MISS=3) -> fault=1 and no avg_val, window unchanged; a following sample of 500 -> fault=0.
REQ-032 rst pulsed 1 cycle after in_val -> no avg_val, all outputs 0; in_val during SUM -> dropped and the window is unchanged.
REQ-033 DIST_MEDIAN_EN: samples 100, 100, 100, 100, 900 -> inserted value 100, avg_dist=100; latency measured as 4 cycles.
